// File: rtl/lcs_div_8bit_pkg.sv
// Shared definitions for the 8-bit restoring divider: FSM states and widths.
package lcs_pkg;

  localparam int WIDTH = 8;
  localparam int CNT_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/lcs_div_8bit_if.sv
// Start/busy/done handshake and operand/result bus of the 8-bit divider.
interface lcs_div_8bit_if;

  logic                      start;
  logic [lcs_pkg::WIDTH-1:0] a;
  logic [lcs_pkg::WIDTH-1:0] b;
  logic                      busy;
  logic                      done_r;
  logic [lcs_pkg::WIDTH-1:0] quo_r;
  logic [lcs_pkg::WIDTH-1:0] rem_r;
  logic                      div_zero_r;

  modport master (
    output start, a, b,
    input  busy, done_r, quo_r, rem_r, div_zero_r
  );

  modport slave (
    input  start, a, b,
    output busy, done_r, quo_r, rem_r, div_zero_r
  );

endinterface

// File: rtl/lcs_div_8bit_bls_sub_9bit.sv
// 9-bit borrow-lookahead subtractor: diff = x - y, bout set when x < y.
module bls_sub_9bit (
  input  logic [8:0] x,
  input  logic [8:0] y,
  output logic [8:0] diff,
  output logic       bout
);

  logic [8:0] g;
  logic [8:0] p;

  // A bit generates a borrow when x=0,y=1 and passes one through when x==y.
  assign g = ~x & y;
  assign p = ~(x ^ y);

  always_comb begin
    logic br;
    br   = 1'b0;
    diff = '0;
    for (int i = 0; i < 9; i++) begin
      diff[i] = x[i] ^ y[i] ^ br;
      br      = g[i] | (p[i] & br);
    end
    bout = br;
  end

endmodule

// File: rtl/lcs_div_8bit.sv
// Sequential 8-bit unsigned restoring divider, one quotient bit per clock.
module lcs_div_8bit
  import lcs_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  lcs_div_8bit_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = '1;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   q_q;
  logic [WIDTH-1:0]   r_q;
  logic [WIDTH-1:0]   d_q;
  logic [WIDTH-1:0]   quo_q;
  logic [WIDTH-1:0]   rem_q;
  logic               dz_q;
  logic               done_q;

  logic [WIDTH:0]     partial;
  logic [WIDTH:0]     diff;
  logic               borrow;
  logic               fits;
  logic [WIDTH-1:0]   q_d;
  logic [WIDTH-1:0]   r_d;

  assign partial = {r_q, q_q[WIDTH-1]};

  bls_sub_9bit u_sub (
    .x    (partial),
    .y    ({1'b0, d_q}),
    .diff (diff),
    .bout (borrow)
  );

  // Since r < d, a borrow-free difference never sets the top bit.
  assign fits = ~borrow & ~diff[WIDTH];
  assign r_d  = fits ? diff[WIDTH-1:0] : partial[WIDTH-1:0];
  assign q_d  = {q_q[WIDTH-2:0], fits};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (bus.b != '0) begin
              q_q     <= bus.a;
              r_q     <= '0;
              d_q     <= bus.b;
              cnt_q   <= '0;
              dz_q    <= 1'b0;
              state_q <= RUN;
            end else begin
              // Divide by zero completes on the accepting edge.
              quo_q  <= '1;
              rem_q  <= bus.a;
              dz_q   <= 1'b1;
              done_q <= 1'b1;
            end
          end
        end
        RUN: begin
          q_q   <= q_d;
          r_q   <= r_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            quo_q   <= q_d;
            rem_q   <= r_d;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy       = (state_q == RUN);
  assign bus.done_r     = done_q;
  assign bus.quo_r      = quo_q;
  assign bus.rem_r      = rem_q;
  assign bus.div_zero_r = dz_q;

endmodule

// File: tb/tb_lcs_div_8bit.sv
// Self-checking bench for lcs_div_8bit: vector table, corner sequences, random ops.
module tb_lcs_div_8bit;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  lcs_div_8bit_if bus ();

  lcs_div_8bit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] quo;
    logic [7:0] rem;
    logic       dz;
  } vec_t;

  vec_t tbl [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: plain integer division with the divide-by-zero convention.
  function automatic logic [16:0] ref_div(input logic [7:0] a, input logic [7:0] b);
    if (b == 8'd0) return {1'b1, 8'hFF, a};
    return {1'b0, 8'(a / b), 8'(a % b)};
  endfunction

  // Issue one operation and wait (bounded) for done_r; lat = edges after acceptance.
  task automatic run_op(input logic [7:0] ia, input logic [7:0] ib,
                        output int lat, output int bcnt);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = ia;
    bus.b     = ib;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = 8'($urandom);
    bus.b     = 8'($urandom);
    lat  = 0;
    bcnt = 0;
    while (!bus.done_r && lat < 20) begin
      if (bus.busy) bcnt++;
      @(posedge clk);
      #1;
      lat++;
    end
    if (!bus.done_r) lat = -1;
  endtask

  task automatic check_result(input string tag, input logic [7:0] a, input logic [7:0] b,
                              input int lat, input int bcnt);
    logic [16:0] e;
    e = ref_div(a, b);
    check({tag, " quo"}, bus.quo_r, e[15:8]);
    check({tag, " rem"}, bus.rem_r, e[7:0]);
    check({tag, " dz"}, bus.div_zero_r, e[16]);
    check({tag, " lat"}, lat, (b == 8'd0) ? 0 : 8);
    check({tag, " busy_cycles"}, bcnt, (b == 8'd0) ? 0 : 8);
  endtask

  initial begin
    int lat, bcnt, dcnt, dedge, c1, c2;
    logic [7:0] ra, rb, gq, gr;

    checks = 0;
    errors = 0;
    tbl[0] = '{a: 8'd200, b: 8'd7,   quo: 8'd28,  rem: 8'd4,   dz: 1'b0};
    tbl[1] = '{a: 8'd100, b: 8'd0,   quo: 8'hFF,  rem: 8'd100, dz: 1'b1};
    tbl[2] = '{a: 8'd0,   b: 8'd255, quo: 8'd0,   rem: 8'd0,   dz: 1'b0};
    tbl[3] = '{a: 8'd255, b: 8'd255, quo: 8'd1,   rem: 8'd0,   dz: 1'b0};
    tbl[4] = '{a: 8'd255, b: 8'd1,   quo: 8'd255, rem: 8'd0,   dz: 1'b0};
    tbl[5] = '{a: 8'd5,   b: 8'd9,   quo: 8'd0,   rem: 8'd5,   dz: 1'b0};
    tbl[6] = '{a: 8'd254, b: 8'd16,  quo: 8'd15,  rem: 8'd14,  dz: 1'b0};

    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    rst       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", bus.busy, 0);
    check("reset done", bus.done_r, 0);
    check("reset quo", bus.quo_r, 0);
    check("reset rem", bus.rem_r, 0);
    check("reset dz", bus.div_zero_r, 0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_op(tbl[i].a, tbl[i].b, lat, bcnt);
      check($sformatf("vec%0d quo", i), bus.quo_r, tbl[i].quo);
      check($sformatf("vec%0d rem", i), bus.rem_r, tbl[i].rem);
      check($sformatf("vec%0d dz", i), bus.div_zero_r, tbl[i].dz);
      check($sformatf("vec%0d lat", i), lat, (tbl[i].b == 8'd0) ? 0 : 8);
      check($sformatf("vec%0d busy_cycles", i), bcnt, (tbl[i].b == 8'd0) ? 0 : 8);
      check($sformatf("vec%0d busy_at_done", i), bus.busy, 0);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d done_pulse_end", i), bus.done_r, 0);
      check($sformatf("vec%0d quo_hold", i), bus.quo_r, tbl[i].quo);
    end

    // Back-to-back: second start lands in the done_r cycle of the first.
    run_op(8'd255, 8'd1, lat, bcnt);
    c1 = lat;
    gq = bus.quo_r;
    gr = bus.rem_r;
    run_op(8'd5, 8'd9, lat, bcnt);
    c2 = lat;
    check("b2b first quo", gq, 255);
    check("b2b first rem", gr, 0);
    check("b2b gap", c1 + 1 + c2, 17);
    check("b2b second quo", bus.quo_r, 0);
    check("b2b second rem", bus.rem_r, 5);

    // A start pulsed mid-division is ignored.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'd200;
    bus.b     = 8'd7;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    dcnt  = 0;
    dedge = -1;
    gq    = '0;
    gr    = '0;
    for (int i = 1; i <= 14; i++) begin
      @(posedge clk);
      #1;
      if (i == 2) begin
        bus.start = 1'b1;
        bus.a     = 8'd9;
        bus.b     = 8'd3;
      end
      if (i == 3) bus.start = 1'b0;
      if (bus.done_r) begin
        dcnt++;
        if (dedge < 0) begin
          dedge = i;
          gq    = bus.quo_r;
          gr    = bus.rem_r;
        end
      end
    end
    check("ignore done_count", dcnt, 1);
    check("ignore done_edge", dedge, 8);
    check("ignore quo", gq, 28);
    check("ignore rem", gr, 4);

    // Asynchronous reset in the middle of a division.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'd13;
    bus.b     = 8'd5;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("midrst busy", bus.busy, 0);
    check("midrst done", bus.done_r, 0);
    check("midrst quo", bus.quo_r, 0);
    check("midrst rem", bus.rem_r, 0);
    check("midrst dz", bus.div_zero_r, 0);
    @(negedge clk);
    rst = 1'b1;
    run_op(8'd200, 8'd7, lat, bcnt);
    check_result("after_rst", 8'd200, 8'd7, lat, bcnt);

    // Randomized operations against the reference model.
    for (int n = 0; n < 40; n++) begin
      ra = 8'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      run_op(ra, rb, lat, bcnt);
      check_result($sformatf("rand%0d(%0d/%0d)", n, ra, rb), ra, rb, lat, bcnt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
